// File: rtl/cnn_mul_share_arb.sv
// Shares one signed 14x9 -> 22-bit multiplier between N_REQ requesters through a
// two-stage pipe. Define CNN_MUL_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module cnn_mul_share_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*14-1:0]   req_a,
    input  logic [N_REQ*9-1:0]    req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [21:0]           rsp_p,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  busy
);

    logic signed [13:0] a_arr [N_REQ];
    logic signed [8:0]  b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[14*gi +: 14];
            assign b_arr[gi] = req_b[9*gi +: 9];
        end
    endgenerate

    logic                   s1_vld_reg;
    logic signed [13:0]     s1_a_reg;
    logic signed [8:0]      s1_b_reg;
    logic [ID_W-1:0]        s1_id_reg;
    logic                   s2_vld_reg;
    logic [21:0]            s2_p_reg;
    logic [ID_W-1:0]        s2_id_reg;

    logic                   s1_en;
    logic                   s2_en;
    logic [N_REQ-1:0]       grant;
    logic [ID_W-1:0]        grant_id;
    logic                   any_grant;
    logic                   accept;
    logic signed [21:0]     prod;

    // A slot opens in S1 whenever the pipe can shift, so a full pipe accepts
    // in the same cycle the consumer becomes ready.
    assign s2_en  = !s2_vld_reg || rsp_ready;
    assign s1_en  = !s1_vld_reg || s2_en;
    assign accept = any_grant && s1_en;

    assign req_ready = grant & {N_REQ{s1_en}};

`ifdef CNN_MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!any_grant && req_valid[k]) begin
                grant[k]  = 1'b1;
                grant_id  = ID_W'(k);
                any_grant = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr_reg;
    int              rr_cand;

    // Search begins just past the last winner, so every requester waits at most N_REQ-1 grants.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        rr_cand   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            rr_cand = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!any_grant && req_valid[rr_cand]) begin
                grant[rr_cand] = 1'b1;
                grant_id       = ID_W'(rr_cand);
                any_grant      = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_reg <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            rr_ptr_reg <= grant_id;
        end
    end
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_vld_reg <= 1'b0;
            s1_a_reg   <= '0;
            s1_b_reg   <= '0;
            s1_id_reg  <= '0;
        end else if (s1_en) begin
            s1_vld_reg <= any_grant;
            if (any_grant) begin
                s1_a_reg  <= a_arr[grant_id];
                s1_b_reg  <= b_arr[grant_id];
                s1_id_reg <= grant_id;
            end
        end
    end

    // Multiplying in a 22-bit context yields the product modulo 2^22 directly.
    assign prod = 22'(s1_a_reg) * 22'(s1_b_reg);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s2_vld_reg <= 1'b0;
            s2_p_reg   <= '0;
            s2_id_reg  <= '0;
        end else if (s2_en) begin
            s2_vld_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                s2_p_reg  <= prod;
                s2_id_reg <= s1_id_reg;
            end
        end
    end

    assign rsp_valid = s2_vld_reg;
    assign rsp_p     = s2_p_reg;
    assign rsp_id    = s2_id_reg;
    assign busy      = s1_vld_reg || s2_vld_reg;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Randomised and directed bench for cnn_mul_share_arb; a transaction-queue model
// predicts grants, response timing and products.
module tb_cnn_mul_share_arb;

    localparam int N   = 4;
    localparam int IDW = 2;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*14-1:0]     req_a;
    logic [N*9-1:0]      req_b;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [21:0]         rsp_p;
    logic [IDW-1:0]      rsp_id;
    logic                busy;

    logic signed [13:0]  a_v [N];
    logic signed [8:0]   b_v [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pack
            assign req_a[14*gi +: 14] = a_v[gi];
            assign req_b[9*gi +: 9]   = b_v[gi];
        end
    endgenerate

    cnn_mul_share_arb #(.N_REQ(N), .ID_W(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [21:0]    p;
        int             cyc;
    } item_t;

    item_t          q[$];
    logic [IDW-1:0] m_ptr;
    int             cyc;
    int             checks;
    int             errors;

    logic [N-1:0]   obs_ready;
    logic           obs_rsp_valid;
    logic [21:0]    obs_rsp_p;
    logic [IDW-1:0] obs_rsp_id;

    function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
        logic [N-1:0] g;
        int idx;
        g = '0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(m_ptr) + k) % N;
            if (v[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ptr = IDW'(N - 1);
    endtask

    // One clock of traffic: compare outputs with the model, then advance the model.
    task automatic run_cycle();
        logic [N-1:0] er;
        logic         ev;
        logic         pop;
        item_t        it;
        #1;
        er = ((q.size() < 2) || rsp_ready) ? model_grant(req_valid) : '0;
        ev = (q.size() > 0) && (q[0].cyc < cyc);
        obs_ready     = req_ready;
        obs_rsp_valid = rsp_valid;
        obs_rsp_p     = rsp_p;
        obs_rsp_id    = rsp_id;
        checks++;
        if (req_ready !== er) begin
            errors++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, er);
        end
        checks++;
        if (rsp_valid !== ev) begin
            errors++;
            $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, ev);
        end
        checks++;
        if (busy !== (q.size() > 0)) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() > 0);
        end
        if (ev && rsp_valid === 1'b1) begin
            checks++;
            if (rsp_id !== q[0].id || rsp_p !== q[0].p) begin
                errors++;
                $display("FAIL rsp_data cyc=%0d got id=%0d p=%h exp id=%0d p=%h",
                         cyc, rsp_id, rsp_p, q[0].id, q[0].p);
            end
        end
        pop = ev && rsp_ready;
        if (er != '0) begin
            it.id = IDW'(onehot_idx(er));
            it.p  = 22'(int'(a_v[it.id]) * int'(b_v[it.id]));
        end
        @(posedge ap_clk);
        cyc++;
        if (pop) void'(q.pop_front());
        if (er != '0) begin
            it.cyc = cyc;
            q.push_back(it);
`ifndef CNN_MUL_ARB_FIXED_PRIO_EN
            m_ptr = it.id;
`endif
        end
        @(negedge ap_clk);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) run_cycle();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d exp 0", q.size());
        end
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end
        repeat (3) @(negedge ap_clk);
        checks++;
        if ({rsp_valid, busy, rsp_p, rsp_id, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b busy=%b p=%h id=%0d rdy=%b exp all 0",
                     rsp_valid, busy, rsp_p, rsp_id, req_ready);
        end
        ap_rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        a_v[0]    = 14'sd100;
        b_v[0]    = -9'sd3;
        rsp_ready = 1'b1;
        run_cycle();
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL single_ready got=%b exp=0001", obs_ready);
        end
        req_valid = '0;
        run_cycle();
        checks++;
        if (obs_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early got rsp_valid=%b exp 0", obs_rsp_valid);
        end
        run_cycle();
        checks++;
        if (obs_rsp_valid !== 1'b1 || $signed(obs_rsp_p) != -300 || obs_rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL single_rsp got v=%b p=%0d id=%0d exp v=1 p=-300 id=0",
                     obs_rsp_valid, $signed(obs_rsp_p), obs_rsp_id);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_round_robin();
        int           start;
        logic [N-1:0] g [12];
        logic [N-1:0] exp_g;
        drain();
        start     = (int'(m_ptr) + 1) % N;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < N; r++) begin
                a_v[r] = 14'($urandom);
                b_v[r] = 9'($urandom);
            end
            run_cycle();
            g[i]  = obs_ready;
            exp_g = '0;
            exp_g[(start + i) % N] = 1'b1;
            checks++;
            if (g[i] !== exp_g) begin
                errors++;
                $display("FAIL rr_order i=%0d got=%b exp=%b", i, g[i], exp_g);
            end
            if (i >= 2) begin
                checks++;
                if (obs_rsp_valid !== 1'b1 || int'(obs_rsp_id) != (start + i - 2) % N) begin
                    errors++;
                    $display("FAIL rr_rsp_id i=%0d got v=%b id=%0d exp v=1 id=%0d",
                             i, obs_rsp_valid, obs_rsp_id, (start + i - 2) % N);
                end
            end
        end
        drain();
    endtask

    task automatic test_stall();
        int           start;
        int           n_acc;
        int           exp_rel;
        logic [N-1:0] exp_g;
        drain();
        start     = (int'(m_ptr) + 1) % N;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        n_acc     = 0;
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            if (obs_ready != '0) n_acc++;
        end
        checks++;
        if (n_acc != 2 || obs_ready !== 4'b0000) begin
            errors++;
            $display("FAIL stall_accepts got=%0d last_rdy=%b exp 2 and 0000", n_acc, obs_ready);
        end
`ifdef CNN_MUL_ARB_FIXED_PRIO_EN
        exp_rel = 0;
`else
        exp_rel = (start + 2) % N;
`endif
        rsp_ready = 1'b1;
        run_cycle();
        exp_g = '0;
        exp_g[exp_rel] = 1'b1;
        checks++;
        if (obs_ready !== exp_g) begin
            errors++;
            $display("FAIL stall_resume got=%b exp=%b", obs_ready, exp_g);
        end
        for (int i = 0; i < 6; i++) run_cycle();
        drain();
    endtask

    int t_idx [4] = '{1, 2, 3, 0};
    int t_a   [4] = '{-8192, 8191, -1, -8192};
    int t_b   [4] = '{-256, 255, 1, 255};
    int t_p   [4] = '{32'h200000, 2088705, -1, -2088960};

    task automatic test_wrap();
        logic [N-1:0] v;
        for (int t = 0; t < 4; t++) begin
            drain();
            v = '0;
            v[t_idx[t]] = 1'b1;
            a_v[t_idx[t]] = 14'(t_a[t]);
            b_v[t_idx[t]] = 9'(t_b[t]);
            req_valid = v;
            run_cycle();
            req_valid = '0;
            run_cycle();
            run_cycle();
            checks++;
            if (obs_rsp_valid !== 1'b1 || obs_rsp_p !== 22'(t_p[t]) || int'(obs_rsp_id) != t_idx[t]) begin
                errors++;
                $display("FAIL wrap_%0d got v=%b p=%h id=%0d exp v=1 p=%h id=%0d", t,
                         obs_rsp_valid, obs_rsp_p, obs_rsp_id, 22'(t_p[t]), t_idx[t]);
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        drain();
        req_valid = 4'b0001;
        a_v[0]    = 14'($urandom);
        b_v[0]    = 9'($urandom);
        rsp_ready = 1'b0;
        run_cycle();
        run_cycle();
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, rsp_p, rsp_id} !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b busy=%b p=%h id=%0d exp all 0",
                     rsp_valid, busy, rsp_p, rsp_id);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        model_reset();
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        run_cycle();
        checks++;
        if (obs_ready !== 4'b0001) begin
            errors++;
            $display("FAIL post_reset_grant got=%b exp=0001", obs_ready);
        end
    endtask

    task automatic test_prio_mode();
        logic [N-1:0] g [6];
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            g[i] = obs_ready;
`ifdef CNN_MUL_ARB_FIXED_PRIO_EN
            checks++;
            if (g[i] !== 4'b0001) begin
                errors++;
                $display("FAIL prio_fixed i=%0d got=%b exp=0001", i, g[i]);
            end
`else
            checks++;
            if ((g[i] !== 4'b0001 && g[i] !== 4'b1000) || (i > 0 && g[i] === g[i-1])) begin
                errors++;
                $display("FAIL prio_alternate i=%0d got=%b exp alternating 0001/1000", i, g[i]);
            end
`endif
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < N; r++) begin
                a_v[r] = 14'($urandom);
                b_v[r] = 9'($urandom);
            end
            run_cycle();
        end
        drain();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        model_reset();
        test_reset();
        test_single();
`ifndef CNN_MUL_ARB_FIXED_PRIO_EN
        test_round_robin();
`endif
        test_stall();
        test_wrap();
        test_reset_midflight();
        test_prio_mode();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
